sccb_master: RTL and testbench
==============================

// Module: sccb_master
// PURPOSE
//  SCCB (OV7725 register-config bus) master driving sioc/siod for the dcmi camera block.
//  Accepts one register write or read per request over a valid/ready handshake.
//  Writes run as 3-phase transactions; reads run as 2-phase write + 2-phase read.
//  Sits between the camera-config sequencer (upstream) and the OV7725 SIOC/SIOD pins.
// PARAMETERS
//  QDIV   125  clk cycles per quarter SIOC period; SIOC = clk/(4*QDIV) (50MHz -> 100kHz); min 2
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  req_valid  in   1  request present
//  req_ready  out  1  block idle, can accept request
//  req_rd     in   1  1=read, 0=write
//  req_id     in   8  device ID; bit0 ignored, forced 0 for write phase, 1 for read phase
//  req_addr   in   8  sub-address
//  req_data   in   8  write data (ignored for reads)
//  done       out  1  1-cycle pulse, transaction finished
//  rd_valid   out  1  1-cycle pulse with done on reads; rd_data valid
//  rd_data    out  8  read byte, held until next read completes
//  sioc       out  1  SCCB clock
//  siod_out   out  1  SIOD drive value
//  siod_oe    out  1  1=drive siod_out; 0=release (pad pulls high)
//  siod_in    in   1  SIOD pad input
// BEHAVIOUR
//  Reset: sioc=1, siod_out=1, siod_oe=1, req_ready=1, done=0, rd_valid=0, rd_data=0, state IDLE.
//  Accept on req_valid&req_ready; all req_* latched that cycle; req_ready=0 next cycle.
//  req_valid while busy is ignored (no queue).
//  Quarter tick: counter 0..QDIV-1, restarted at accept; all bus activity advances on ticks.
//  Bit = 4 quarters: Q0 sioc=0, siod updated; Q1 sioc=0; Q2,Q3 sioc=1.
//  siod_in sampled at start of Q3. MSB first.
//  Phase = 9 bits: 8 data bits + 9th bit.
//   - 9th bit on write phases: siod_oe=0 (don't-care), sampled value ignored, no NACK abort.
//   - 9th bit on read data phase: master drives NA=1.
//   - Read data bits 0-7: siod_oe=0, bits shifted into rd_data.
//  States and quarter counts:
//   IDLE  ->  START (2Q)   sioc=1, siod=0
//         ->  PH (36Q per phase)
//         ->  STOP (3Q)    Q0 sioc=0, siod=0; Q1 sioc=1, siod=0; Q2 sioc=1, siod=1
//         ->  GAP (4Q)     bus idle
//         ->  IDLE
//  Write: START, PH(id&FE), PH(addr), PH(data), STOP, GAP = 117Q.
//  Read:  START, PH(id&FE), PH(addr), STOP, GAP, START, PH(id|01), PH(read), STOP, GAP = 162Q.
//  done (and rd_valid, for reads) asserts in last cycle of GAP.
//   - Write: exactly 117*QDIV cycles after accept cycle. Read: 162*QDIV cycles.
//  req_ready returns to 1 in the same cycle as done; a new request may be accepted then.
//  rd_data updates only at read completion; writes leave it unchanged.
//  rst mid-transfer: outputs return to reset values immediately; transaction abandoned;
//   no done issued. Spurious stop on the bus is acceptable.
//  Quarter counter and bit counter widths: $clog2(QDIV) and 4 bits; no wrap beyond 8 (bit index 0..8).
// TESTING
//  1) QDIV=2; write id=0x42 addr=0x12 data=0x80.
//     -> bytes at sioc rises 0x42,0x12,0x80; siod_oe=0 on each 9th bit; done 234 cycles after accept.
//  2) Read id=0x43 addr=0x0A; slave model returns 0xA5.
//     -> phase ids 0x42 then 0x43; siod_oe=0 for 8 data bits; NA=1 driven.
//     -> rd_data=0xA5, rd_valid&done at cycle 324.
//  3) Write req_id=0x43 -> first phase byte on bus is 0x42.
//  4) Two write requests, second held valid during busy.
//     -> second accepted in done cycle; no extra gap; req_valid toggles during busy ignored.
//  5) Assert rst at quarter 50 of a write.
//     -> sioc=1, siod_out=1, siod_oe=1, req_ready=1 immediately; no done pulse.
//     -> next write completes correctly.
//  6) Bus checker on all tests: siod changes only while sioc=0, except START/STOP edges.
//     -> sioc high/low each exactly 2*QDIV cycles.

Source files
------------

// File: rtl/sccb_master.sv
// SCCB master for the OV7725 config port: one register write (3 phases) or read
// (2-phase write + 2-phase read) per request, paced by a QDIV-cycle quarter tick.
module sccb_master #(
    parameter int QDIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [7:0] req_id,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    input  logic       siod_in
);
    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_PH, S_STOP, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qi_q, qi_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    ph_q, ph_d;
    logic          seg_q, seg_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_q, rd_d;
    logic [6:0]    id_q, id_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;

    logic       tick, accept, rd_phase, last_ph, last_seg;
    logic [7:0] tx_byte;
    logic       unused_id0;

    assign unused_id0 = req_id[0];

    // Handshake: a request transfers on any cycle where req_valid && req_ready;
    // req_ready is high in IDLE and in the done cycle, otherwise req_valid is ignored.
    assign tick      = (qcnt_q == QLAST);
    assign last_seg  = ~rd_q | seg_q;
    assign done      = (state_q == S_GAP) && (qi_q == 2'd3) && tick && last_seg;
    assign rd_valid  = done & rd_q;
    assign req_ready = (state_q == S_IDLE) | done;
    assign accept    = req_valid & req_ready;
    assign rd_phase  = rd_q & seg_q & (ph_q == 2'd1);
    assign last_ph   = rd_q ? (ph_q == 2'd1) : (ph_q == 2'd2);
    // Read data is visible in the completion cycle itself, then held.
    assign rd_data   = rd_valid ? sh_q : rd_data_q;

    // The second segment of a read re-sends the ID with the read bit set.
    always_comb begin
        tx_byte = addr_q;
        if (ph_q == 2'd0) begin
            tx_byte = {id_q, seg_q};
        end else if (ph_q == 2'd2) begin
            tx_byte = data_q;
        end
    end

    always_comb begin
        sioc     = 1'b1;
        siod_out = 1'b1;
        siod_oe  = 1'b1;
        case (state_q)
            S_START: siod_out = 1'b0;
            S_PH: begin
                sioc = qi_q[1];
                if (bit_q == 4'd8) begin
                    siod_oe  = rd_phase;
                    siod_out = 1'b1;
                end else begin
                    siod_oe  = ~rd_phase;
                    siod_out = tx_byte[~bit_q[2:0]];
                end
            end
            S_STOP: begin
                sioc     = (qi_q != 2'd0);
                siod_out = (qi_q == 2'd2);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        qi_d      = qi_q;
        bit_d     = bit_q;
        ph_d      = ph_q;
        seg_d     = seg_q;
        sh_d      = sh_q;
        rd_data_d = rd_data_q;
        rd_d      = rd_q;
        id_d      = id_q;
        addr_d    = addr_q;
        data_d    = data_q;
        qcnt_d    = (state_q == S_IDLE || tick) ? '0 : qcnt_q + QW'(1);
        case (state_q)
            S_START: if (tick) begin
                if (qi_q == 2'd1) begin
                    state_d = S_PH;
                    qi_d    = 2'd0;
                    bit_d   = 4'd0;
                end else begin
                    qi_d = qi_q + 2'd1;
                end
            end
            S_PH: if (tick) begin
                qi_d = qi_q + 2'd1;
                // Leaving Q2 is the start of Q3: sample the slave's data bit.
                if (qi_q == 2'd2 && rd_phase && bit_q != 4'd8) begin
                    sh_d = {sh_q[6:0], siod_in};
                end
                if (qi_q == 2'd3) begin
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (last_ph) begin
                            state_d = S_STOP;
                        end else begin
                            ph_d = ph_q + 2'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_STOP: if (tick) begin
                if (qi_q == 2'd2) begin
                    state_d = S_GAP;
                    qi_d    = 2'd0;
                end else begin
                    qi_d = qi_q + 2'd1;
                end
            end
            S_GAP: if (tick) begin
                qi_d = qi_q + 2'd1;
                if (qi_q == 2'd3) begin
                    if (last_seg) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_START;
                        seg_d   = 1'b1;
                        ph_d    = 2'd0;
                    end
                end
            end
            default: ;
        endcase
        if (rd_valid) begin
            rd_data_d = sh_q;
        end
        if (accept) begin
            state_d = S_START;
            qcnt_d  = '0;
            qi_d    = 2'd0;
            bit_d   = 4'd0;
            ph_d    = 2'd0;
            seg_d   = 1'b0;
            rd_d    = req_rd;
            id_d    = req_id[7:1];
            addr_d  = req_addr;
            data_d  = req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qi_q      <= 2'd0;
            bit_q     <= 4'd0;
            ph_q      <= 2'd0;
            seg_q     <= 1'b0;
            sh_q      <= 8'd0;
            rd_data_q <= 8'd0;
            rd_q      <= 1'b0;
            id_q      <= 7'd0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qi_q      <= qi_d;
            bit_q     <= bit_d;
            ph_q      <= ph_d;
            seg_q     <= seg_d;
            sh_q      <= sh_d;
            rd_data_q <= rd_data_d;
            rd_q      <= rd_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: quarter-level waveform model per request, per-cycle compare,
// bus monitor (start/stop counts, bytes at sioc rises) and directed literal checks.
module tb_sccb_master;
  localparam int QDIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rd = 1'b0;
  logic [7:0] req_id = 8'h00;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       done, rd_valid;
  logic [7:0] rd_data;
  logic       sioc, siod_out, siod_oe, siod_in;
  logic       slv = 1'b1;
  logic [7:0] sbyte = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // entry bits: {sioc, oe, out, slave_bit, done, rd_valid}
  logic [5:0] exp_q[$];
  logic [7:0] rdb_q[$];
  logic [7:0] mon_q[$];
  logic [7:0] rd_exp = 8'h00;
  int         nstart = 0, nstop = 0, bitn = 0;
  logic [8:0] msh = 9'd0;
  logic       prev_sioc = 1'b1, prev_line = 1'b1;

  sccb_master #(.QDIV(QDIV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_id(req_id), .req_addr(req_addr), .req_data(req_data),
    .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
    .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .siod_in(siod_in)
  );

  assign siod_in = siod_oe ? siod_out : slv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void push_q(logic sc, logic oe, logic o, logic sv);
    for (int k = 0; k < QDIV; k++) exp_q.push_back({sc, oe, o, sv, 2'b00});
  endfunction

  function automatic void push_start();
    push_q(1'b1, 1'b1, 1'b0, 1'b1);
    push_q(1'b1, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic void push_stop_gap();
    push_q(1'b0, 1'b1, 1'b0, 1'b1);
    push_q(1'b1, 1'b1, 1'b0, 1'b1);
    push_q(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) push_q(1'b1, 1'b1, 1'b1, 1'b1);
  endfunction

  function automatic void push_byte(logic [7:0] b, logic rdph, logic [7:0] sb);
    for (int i = 0; i < 9; i++) begin
      logic oe, o, sv;
      if (i < 8) begin
        oe = ~rdph;
        o  = b[7-i];
        sv = sb[7-i];
      end else begin
        oe = rdph;
        o  = 1'b1;
        sv = 1'($urandom_range(0, 1));
      end
      push_q(1'b0, oe, o, sv);
      push_q(1'b0, oe, o, sv);
      push_q(1'b1, oe, o, sv);
      push_q(1'b1, oe, o, sv);
    end
  endfunction

  function automatic void model_req(logic rd, logic [7:0] id, logic [7:0] ad,
                                    logic [7:0] dt, logic [7:0] sb);
    logic [7:0] b0;
    logic [5:0] last;
    b0 = {id[7:1], 1'b0};
    push_start();
    push_byte(b0, 1'b0, 8'h00);
    push_byte(ad, 1'b0, 8'h00);
    if (!rd) push_byte(dt, 1'b0, 8'h00);
    push_stop_gap();
    if (rd) begin
      b0[0] = 1'b1;
      push_start();
      push_byte(b0, 1'b0, 8'h00);
      push_byte(8'hFF, 1'b1, sb);
      push_stop_gap();
      rdb_q.push_back(sb);
    end
    last = exp_q.pop_back();
    last[1] = 1'b1;
    last[0] = rd;
    exp_q.push_back(last);
  endfunction

  // ---------------- per-cycle compare + bus monitor ----------------
  always @(negedge clk) begin : cmp
    logic [5:0] cur;
    logic       was_empty, line;
    if (rst) begin
      exp_q.delete();
      rdb_q.delete();
      rd_exp = 8'h00;
      slv = 1'b1;
      nstart = 0; nstop = 0; bitn = 0;
      prev_sioc = 1'b1; prev_line = 1'b1;
      chk("rst_sioc", 32'(sioc), 32'd1);
      chk("rst_siod_oe", 32'(siod_oe), 32'd1);
      chk("rst_siod_out", 32'(siod_out), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
    end else begin
      was_empty = (exp_q.size() == 0);
      if (was_empty) cur = 6'b111100;
      else cur = exp_q.pop_front();
      slv = cur[2];
      if (cur[1] && cur[0]) rd_exp = rdb_q.pop_front();
      chk("sioc", 32'(sioc), 32'(cur[5]));
      chk("siod_oe", 32'(siod_oe), 32'(cur[4]));
      if (cur[4]) chk("siod_out", 32'(siod_out), 32'(cur[3]));
      chk("done", 32'(done), 32'(cur[1]));
      chk("rd_valid", 32'(rd_valid), 32'(cur[0]));
      chk("req_ready", 32'(req_ready), 32'(was_empty | cur[1]));
      chk("rd_data", 32'(rd_data), 32'(rd_exp));

      line = siod_oe ? siod_out : slv;
      if (prev_sioc && sioc && prev_line && !line) begin
        nstart++;
        bitn = 0;
      end else if (prev_sioc && sioc && !prev_line && line) begin
        nstop++;
      end else if (!prev_sioc && sioc) begin
        chk("bus_siod_stable_at_rise", 32'(line), 32'(prev_line));
        msh = {msh[7:0], line};
        bitn++;
        if (bitn == 9) begin
          mon_q.push_back(msh[8:1]);
          bitn = 0;
        end
      end
      if (cur[1]) begin
        chk("bus_start_count", nstart, cur[0] ? 2 : 1);
        chk("bus_stop_count", nstop, cur[0] ? 2 : 1);
        nstart = 0;
        nstop = 0;
      end
      prev_sioc = sioc;
      prev_line = line;

      if (req_valid && (was_empty || cur[1]))
        model_req(req_rd, req_id, req_addr, req_data, sbyte);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rd, input logic [7:0] id, input logic [7:0] ad,
                       input logic [7:0] dt, input logic [7:0] sb, output int acc);
    int n;
    req_rd = rd; req_id = id; req_addr = ad; req_data = dt; sbyte = sb;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 2000);
    chk("accept_timeout", 32'(req_ready), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 1000);
    chk("done_timeout", 32'(done), 32'd1);
    dc = cyc;
  endtask

  task automatic chk_bytes(input string nm, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, mon_q.size(), n);
    for (int i = 0; i < n && i < mon_q.size(); i++) chk({nm, "_byte"}, 32'(mon_q[i]), 32'(e[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int a, d, d1, d2;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: write 0x42/0x12/0x80
    mon_q.delete();
    issue(1'b0, 8'h42, 8'h12, 8'h80, 8'h00, a);
    wait_done(d);
    chk("t1_latency", d - a, 234);
    chk_bytes("t1", 3, 8'h42, 8'h12, 8'h80, 8'h00);
    @(posedge clk); #1;

    // T2: read 0x43/0x0A, slave returns 0xA5
    mon_q.delete();
    issue(1'b1, 8'h43, 8'h0A, 8'h00, 8'hA5, a);
    wait_done(d);
    chk("t2_latency", d - a, 324);
    chk("t2_rd_valid", 32'(rd_valid), 32'd1);
    chk("t2_rd_data", 32'(rd_data), 32'hA5);
    chk_bytes("t2", 4, 8'h42, 8'h0A, 8'h43, 8'hA5);
    @(posedge clk); #1;

    // T3: write with id bit0 set
    mon_q.delete();
    issue(1'b0, 8'h43, 8'h55, 8'hAA, 8'h00, a);
    wait_done(d);
    chk_bytes("t3", 3, 8'h42, 8'h55, 8'hAA, 8'h00);
    chk("t3_rd_data_held", 32'(rd_data), 32'hA5);
    @(posedge clk); #1;

    // T4: second request held (after junk toggles) while busy
    issue(1'b0, 8'h20, 8'h01, 8'h02, 8'h00, a);
    for (int k = 0; k < 30; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_rd = 1'($urandom_range(0, 1));
      req_id = 8'($urandom);
      @(posedge clk); #1;
    end
    req_rd = 1'b0; req_id = 8'h60; req_addr = 8'h34; req_data = 8'h56; req_valid = 1'b1;
    wait_done(d1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done(d2);
    chk("t4_first_latency", d1 - a, 234);
    chk("t4_back_to_back", d2 - d1, 234);
    @(posedge clk); #1;

    // T5: reset in quarter 50 of a write, then a clean write
    issue(1'b0, 8'h42, 8'h01, 8'h02, 8'h00, a);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_sioc", 32'(sioc), 32'd1);
    chk("t5_siod_out", 32'(siod_out), 32'd1);
    chk("t5_siod_oe", 32'(siod_oe), 32'd1);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_q.delete();
    issue(1'b0, 8'h42, 8'h3C, 8'hC3, 8'h00, a);
    wait_done(d);
    chk("t5_after_latency", d - a, 234);
    chk_bytes("t5", 3, 8'h42, 8'h3C, 8'hC3, 8'h00);
    @(posedge clk); #1;

    // Randomized requests
    for (int t = 0; t < 40; t++) begin
      logic rd;
      rd = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(rd, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), a);
      wait_done(d);
      chk("rand_latency", d - a, rd ? 324 : 234);
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
